// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the pipeline, load/store, debug and register-file signals that
// pass through the write-port arbiter. The arbiter binds the slave modport;
// the surrounding core (or a bench) drives through the master modport.
interface regfile_wb_arbiter_if;
    logic        exe_wr_en_i;
    logic [4:0]  exe_waddr_i;
    logic [31:0] exe_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic [31:0] pend_mask_o;
    logic        dbg_halted_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic [4:0]  cpu_raddr_a_i;
    logic [4:0]  rf_raddr_a_o;
    logic [31:0] rf_rdata_a_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    modport slave (
        input  exe_wr_en_i, exe_waddr_i, exe_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o, pend_mask_o,
        input  dbg_halted_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o,
        input  cpu_raddr_a_i, rf_rdata_a_i,
        output rf_raddr_a_o, rf_wr_en_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output exe_wr_en_i, exe_waddr_i, exe_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o, pend_mask_o,
        output dbg_halted_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o,
        output cpu_raddr_a_i, rf_rdata_a_i,
        input  rf_raddr_a_o, rf_wr_en_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: execute writeback has absolute priority,
// buffered load results drain from a small FIFO when exe is idle, and debug
// writes go last. While the core is halted a debug FSM can also borrow read
// port A for one access.
module regfile_wb_arbiter #(
    parameter int LSU_DEPTH = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_ACK     = 3'd4
    } dbg_state_t;

    logic [4:0]  fifo_addr_r [LSU_DEPTH];
    logic [31:0] fifo_data_r [LSU_DEPTH];
    logic [PW:0] wr_ptr_r;
    logic [PW:0] rd_ptr_r;
    logic [PW:0] count_s;
    logic        empty_s;
    logic        full_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] mask_s;

    dbg_state_t  state_r;
    dbg_state_t  state_n_s;
    logic        latch_s;
    logic        capture_s;
    logic [4:0]  dbg_addr_r;
    logic [31:0] dbg_wdata_r;
    logic [31:0] dbg_rdata_r;

    logic        wr_en_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;
    logic [4:0]  raddr_s;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                     (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    // Loads to x0 are acknowledged through ready but never stored.
    assign push_s  = bus.lsu_valid_i && !full_s && (bus.lsu_waddr_i != 5'd0);
    // The head is granted whenever exe leaves the port free.
    assign pop_s   = !empty_s && !bus.exe_wr_en_i;

    // FIFO pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r[PW-1:0]] <= bus.lsu_waddr_i;
            fifo_data_r[wr_ptr_r[PW-1:0]] <= bus.lsu_wdata_i;
        end
    end

    // Pending-load mask: a slot is live when its distance from the head is below the occupancy.
    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            mask_s = mask_s |
                     (({1'b0, PW'(PW'(i) - rd_ptr_r[PW-1:0])} < count_s) ?
                      (32'd1 << fifo_addr_r[i]) : 32'd0);
        end
    end

    assign bus.lsu_ready_o = !full_s;
    assign bus.pend_mask_o = mask_s;

    // Debug FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dbg_req_i && bus.dbg_halted_i) begin
                    latch_s   = 1'b1;
                    state_n_s = bus.dbg_we_i ? ST_WR : ST_RD;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_n_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                capture_s = 1'b1;
                state_n_s = ST_ACK;
            end
            ST_WR: begin
                if (!bus.exe_wr_en_i && empty_s) begin
                    state_n_s = ST_ACK;
                end else begin
                    state_n_s = ST_WR;
                end
            end
            ST_ACK: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Debug FSM state and latched request/response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            dbg_addr_r  <= 5'd0;
            dbg_wdata_r <= 32'd0;
            dbg_rdata_r <= 32'd0;
        end else begin
            state_r <= state_n_s;
            if (latch_s) begin
                dbg_addr_r  <= bus.dbg_addr_i;
                dbg_wdata_r <= bus.dbg_wdata_i;
            end
            if (capture_s) begin
                dbg_rdata_r <= (dbg_addr_r == 5'd0) ? 32'd0 : bus.rf_rdata_a_i;
            end
        end
    end

    // Write-port grant: exe, then FIFO head, then debug; x0 targets are consumed without writing.
    always_comb begin
        wr_en_s = 1'b0;
        waddr_s = 5'd0;
        wdata_s = 32'd0;
        if (bus.exe_wr_en_i) begin
            wr_en_s = (bus.exe_waddr_i != 5'd0);
            waddr_s = bus.exe_waddr_i;
            wdata_s = bus.exe_wdata_i;
        end else if (!empty_s) begin
            wr_en_s = (fifo_addr_r[rd_ptr_r[PW-1:0]] != 5'd0);
            waddr_s = fifo_addr_r[rd_ptr_r[PW-1:0]];
            wdata_s = fifo_data_r[rd_ptr_r[PW-1:0]];
        end else if (state_r == ST_WR) begin
            wr_en_s = (dbg_addr_r != 5'd0);
            waddr_s = dbg_addr_r;
            wdata_s = dbg_wdata_r;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read port A is borrowed only during the single RD cycle.
    always_comb begin
        raddr_s = bus.cpu_raddr_a_i;
        if (state_r == ST_RD) begin
            raddr_s = dbg_addr_r;
        end else begin
            raddr_s = bus.cpu_raddr_a_i;
        end
    end

    assign bus.rf_wr_en_o   = wr_en_s;
    assign bus.rf_waddr_o   = waddr_s;
    assign bus.rf_wdata_o   = wdata_s;
    assign bus.rf_raddr_a_o = raddr_s;
    assign bus.dbg_ack_o    = (state_r == ST_ACK);
    assign bus.dbg_rdata_o  = dbg_rdata_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a queue-based reference model predicts, per
// cycle, the register-file writes, debug acks and status outputs; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.LSU_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Register file stand-in with registered read port A.
    logic [31:0] rf_regs [32] = '{default: 32'd0};
    logic [31:0] rf_rdata_q = 32'd0;
    always @(posedge clk) begin
        if (bus.rf_wr_en_o) rf_regs[bus.rf_waddr_o] <= bus.rf_wdata_o;
        rf_rdata_q <= rf_regs[bus.rf_raddr_a_o];
    end
    assign bus.rf_rdata_a_i = rf_rdata_q;

    typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { int cyc; logic rdy; logic [31:0] mask; logic [4:0] raddr; logic [31:0] rdata; } st_t;

    wr_t exp_wr[$];
    int  exp_ack[$];
    st_t exp_st[$];
    wr_t mq[$];
    logic [31:0] mregs [32] = '{default: 32'd0};

    int cyc = 0, tests = 0, fails = 0;
    bit mon_on = 1'b0;

    // Reference-model debug transaction bookkeeping.
    int dbg_kind = 0;          // 0 none, 1 read, 2 write
    int acc_cyc = 0, ack_cyc = -10, idle_from = 0, last_ack = -10;
    bit wr_done = 1'b0;
    logic [4:0]  dbg_a = 5'd0;
    logic [31:0] dbg_d = 32'd0, rd_snap = 32'd0, m_rdata = 32'd0;

    task automatic drive(input logic r, input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic hal, input logic rq, input logic we, input logic [4:0] da,
                         input logic [31:0] dd, input logic [4:0] cra);
        st_t s;
        wr_t w;
        logic [31:0] mk;
        bit rdy;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        bus.exe_wr_en_i = ee;  bus.exe_waddr_i = ea;  bus.exe_wdata_i = ed;
        bus.lsu_valid_i = lv;  bus.lsu_waddr_i = la;  bus.lsu_wdata_i = ld;
        bus.dbg_halted_i = hal; bus.dbg_req_i = rq;   bus.dbg_we_i = we;
        bus.dbg_addr_i = da;   bus.dbg_wdata_i = dd; bus.cpu_raddr_a_i = cra;
        mon_on = 1'b1;
        if (r) begin
            mq.delete();
            dbg_kind = 0; idle_from = 0; m_rdata = 32'd0;
        end
        if (dbg_kind == 1 && cyc == ack_cyc) m_rdata = (dbg_a == 5'd0) ? 32'd0 : rd_snap;
        rdy = (mq.size() < DEPTH);
        mk = 32'd0;
        foreach (mq[i]) mk[mq[i].a] = 1'b1;
        s.cyc = cyc; s.rdy = rdy; s.mask = mk; s.rdata = m_rdata;
        s.raddr = (dbg_kind == 1 && cyc == acc_cyc + 1) ? dbg_a : cra;
        exp_st.push_back(s);
        if (dbg_kind == 1 && cyc == acc_cyc + 1) rd_snap = mregs[dbg_a];
        // Port grant for this cycle, from the priority rules.
        w.cyc = cyc;
        if (ee) begin
            if (ea != 5'd0) begin
                w.a = ea; w.d = ed; exp_wr.push_back(w); mregs[ea] = ed;
            end
        end else if (mq.size() > 0) begin
            w = mq.pop_front(); w.cyc = cyc;
            exp_wr.push_back(w); mregs[w.a] = w.d;
        end else if (dbg_kind == 2 && cyc > acc_cyc && !wr_done) begin
            wr_done = 1'b1; ack_cyc = cyc + 1;
            if (dbg_a != 5'd0) begin
                w.a = dbg_a; w.d = dbg_d; exp_wr.push_back(w); mregs[dbg_a] = dbg_d;
            end
        end
        if (!r && lv && rdy && la != 5'd0) begin
            w.cyc = 0; w.a = la; w.d = ld; mq.push_back(w);
        end
        if (dbg_kind != 0 && cyc == ack_cyc) begin
            exp_ack.push_back(cyc); last_ack = cyc; dbg_kind = 0; idle_from = cyc + 1;
        end
        if (!r && dbg_kind == 0 && cyc >= idle_from && rq && hal) begin
            dbg_kind = we ? 2 : 1; acc_cyc = cyc; dbg_a = da; dbg_d = dd; wr_done = 1'b0;
            ack_cyc = we ? 32'h3fff_ffff : cyc + 3;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'($urandom));
    endtask

    task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, we, a, d, 5'd1);
            if (last_ack == cyc) got = 1'b1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL dbg_timeout addr=%0d: no ack within 100 cycles, required an ack", a);
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd2);
    endtask

    // Monitor: compares every DUT write, ack and status against the queued predictions.
    wr_t me;
    st_t ms;
    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
                me = exp_wr.pop_front(); tests++; fails++;
                $display("FAIL wr_missing cyc=%0d: no write seen, required x%0d=%h", me.cyc, me.a, me.d);
            end
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                me = exp_wr.pop_front(); tests++;
                if (bus.rf_wr_en_o !== 1'b1 || bus.rf_waddr_o !== me.a || bus.rf_wdata_o !== me.d) begin
                    fails++;
                    $display("FAIL wr cyc=%0d: got en=%b x%0d=%h, required en=1 x%0d=%h",
                             cyc, bus.rf_wr_en_o, bus.rf_waddr_o, bus.rf_wdata_o, me.a, me.d);
                end
            end else if (bus.rf_wr_en_o !== 1'b0) begin
                tests++; fails++;
                $display("FAIL wr_unexpected cyc=%0d: got en=%b x%0d=%h, required en=0",
                         cyc, bus.rf_wr_en_o, bus.rf_waddr_o, bus.rf_wdata_o);
            end
            while (exp_ack.size() > 0 && exp_ack[0] < cyc) begin
                tests++; fails++;
                $display("FAIL ack_missing cyc=%0d: no ack seen, required ack", exp_ack.pop_front());
            end
            if (exp_ack.size() > 0 && exp_ack[0] == cyc) begin
                void'(exp_ack.pop_front()); tests++;
                if (bus.dbg_ack_o !== 1'b1) begin
                    fails++;
                    $display("FAIL ack cyc=%0d: got %b, required 1", cyc, bus.dbg_ack_o);
                end
            end else if (bus.dbg_ack_o !== 1'b0) begin
                tests++; fails++;
                $display("FAIL ack_unexpected cyc=%0d: got %b, required 0", cyc, bus.dbg_ack_o);
            end
            if (exp_st.size() == 0 || exp_st[0].cyc != cyc) begin
                tests++; fails++;
                $display("FAIL status_missing cyc=%0d: no prediction queued", cyc);
            end else begin
                ms = exp_st.pop_front(); tests++;
                if (bus.lsu_ready_o !== ms.rdy || bus.pend_mask_o !== ms.mask ||
                    bus.rf_raddr_a_o !== ms.raddr || bus.dbg_rdata_o !== ms.rdata) begin
                    fails++;
                    $display("FAIL status cyc=%0d: got rdy=%b mask=%h raddr=%0d rdata=%h, required rdy=%b mask=%h raddr=%0d rdata=%h",
                             cyc, bus.lsu_ready_o, bus.pend_mask_o, bus.rf_raddr_a_o, bus.dbg_rdata_o,
                             ms.rdy, ms.mask, ms.raddr, ms.rdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit r_req = 1'b0, r_we = 1'b0;
    logic [4:0]  r_a = 5'd0;
    logic [31:0] r_d = 32'd0;

    initial begin
        bus.exe_wr_en_i = 1'b0; bus.exe_waddr_i = 5'd0; bus.exe_wdata_i = 32'd0;
        bus.lsu_valid_i = 1'b0; bus.lsu_waddr_i = 5'd0; bus.lsu_wdata_i = 32'd0;
        bus.dbg_halted_i = 1'b0; bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0;
        bus.dbg_addr_i = 5'd0; bus.dbg_wdata_i = 32'd0; bus.cpu_raddr_a_i = 5'd0;

        // Reset, then exe writes to x5 and x0.
        for (int k = 0; k < 3; k++)
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3);
        drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5);
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);

        // Loads x3, x4 queued behind three exe cycles; third load refused while full.
        drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'hA, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'hB, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd6, 32'hC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(3);

        // Push and pop together at occupancy 1; load to x0 dropped.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h101, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h103, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(2);

        // Debug reads of x7 and x0.
        drive(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        dbg_txn(1'b0, 5'd7, 32'd0);
        dbg_txn(1'b0, 5'd0, 32'd0);

        // Debug write x9 requested while exe is busy and the FIFO is full.
        drive(1'b0, 1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd17, 32'h17, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h55, 5'd0);
        dbg_txn(1'b1, 5'd9, 32'h55);
        dbg_txn(1'b0, 5'd9, 32'd0);

        // Request while not halted: must never be accepted.
        for (int k = 0; k < 8; k++)
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd7, 32'd0, 5'd4);
        idle(2);

        // Reset during RD_WAIT with a full FIFO.
        drive(1'b0, 1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'hA, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd21, 32'h21, 1'b1, 5'd4, 32'hB, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd23, 32'h23, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd6);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd6);
        idle(4);

        // Randomized traffic on all three sources.
        for (int k = 0; k < 1500; k++) begin
            if (r_req && last_ack == cyc) begin
                r_req = 1'b0;
            end else if (!r_req && $urandom_range(0, 7) == 0) begin
                r_req = 1'b1; r_we = 1'($urandom_range(0, 1)); r_a = 5'($urandom); r_d = $urandom;
            end
            if ($urandom_range(0, 399) == 0)
                drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, r_req, r_we, r_a, r_d, 5'($urandom));
            else
                drive(1'b0, $urandom_range(0, 9) < 4, 5'($urandom), $urandom,
                      $urandom_range(0, 9) < 4, 5'($urandom), $urandom,
                      $urandom_range(0, 3) != 0, r_req, r_we, r_a, r_d, 5'($urandom));
        end
        r_req = 1'b0;
        idle(40);

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        tests++;
        if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d writes and %0d acks still expected, required 0 and 0",
                     exp_wr.size(), exp_ack.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
